tt_sweep_ctrl: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 19 +
 rtl/tt_sweep_ctrl_if.sv | 37 +++
 rtl/tt_settle_timer.sv | 26 ++
 rtl/tt_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Optional macro TT_SWEEP_EARLY_ABORT_EN is consumed by the interface and top.
package tt_sweep_pkg;

  localparam int unsigned N_IN_DEF = 4;
  localparam int unsigned TT_W     = 1 << N_IN_DEF;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic mismatch_bit(input logic f, input logic exp_bit);
    return f ^ exp_bit;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Request/result bundle between a sweep requester (master) and tt_sweep_ctrl (slave).
// fail_idx exists only when TT_SWEEP_EARLY_ABORT_EN is defined.
interface tt_sweep_ctrl_if
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEF
);
  logic                   start;
  logic [(1<<N_IN)-1:0]   expected;
  logic [N_IN-1:0]        vec;
  logic                   f_in;
  logic                   busy;
  logic                   done;
  logic [(1<<N_IN)-1:0]   tt;
  logic [N_IN:0]          mismatch_cnt;
  logic                   pass;
`ifdef TT_SWEEP_EARLY_ABORT_EN
  logic [N_IN-1:0]        fail_idx;
`endif

  modport master (
    output start, expected, f_in,
`ifdef TT_SWEEP_EARLY_ABORT_EN
    input  fail_idx,
`endif
    input  vec, busy, done, tt, mismatch_cnt, pass
  );

  modport slave (
    input  start, expected, f_in,
`ifdef TT_SWEEP_EARLY_ABORT_EN
    output fail_idx,
`endif
    output vec, busy, done, tt, mismatch_cnt, pass
  );

endinterface

// File: rtl/tt_settle_timer.sv
// Per-vector settle counter: strobes sample_now on the last cycle of each vector window.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic sample_now
);

  logic [CNT_W-1:0] cnt;

  assign sample_now = en && (cnt == CNT_W'(SETTLE_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sample_now ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweep of an N_IN-input function with compare against a latched table.
// Define TT_SWEEP_EARLY_ABORT_EN to stop at the first mismatch and report fail_idx.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN          = N_IN_DEF,
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  tt_sweep_ctrl_if.slave  bus
);

  localparam int unsigned TW = 1 << N_IN;

  state_t          state_q, state_nx;
  logic [N_IN-1:0] vec_q, vec_nx;
  logic [TW-1:0]   tt_q, tt_nx;
  logic [TW-1:0]   exp_q, exp_nx;
  logic [N_IN:0]   mm_q, mm_nx;
  logic            busy_q, busy_nx;
  logic            done_q;
  logic            pass_q, pass_nx;
  logic            load;
  logic            sample_now;
  logic            miss;
  logic            stop;
`ifdef TT_SWEEP_EARLY_ABORT_EN
  logic [N_IN-1:0] fidx_q, fidx_nx;
`endif

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .en         (state_q == RUN),
    .sample_now (sample_now)
  );

  assign miss = mismatch_bit(bus.f_in, exp_q[vec_q]);
`ifdef TT_SWEEP_EARLY_ABORT_EN
  assign stop = (vec_q == '1) || miss;
`else
  assign stop = (vec_q == '1);
`endif

  always_comb begin
    state_nx = state_q;
    vec_nx   = vec_q;
    tt_nx    = tt_q;
    exp_nx   = exp_q;
    mm_nx    = mm_q;
    busy_nx  = busy_q;
    pass_nx  = pass_q;
    load     = 1'b0;
`ifdef TT_SWEEP_EARLY_ABORT_EN
    fidx_nx  = fidx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_nx   = bus.expected;
          tt_nx    = '0;
          mm_nx    = '0;
          pass_nx  = 1'b0;
          vec_nx   = '0;
          busy_nx  = 1'b1;
          load     = 1'b1;
          state_nx = RUN;
`ifdef TT_SWEEP_EARLY_ABORT_EN
          fidx_nx  = '0;
`endif
        end
      end
      RUN: begin
        if (sample_now) begin
          tt_nx[vec_q] = bus.f_in;
          if (miss) begin
            mm_nx = mm_q + (N_IN+1)'(1);
`ifdef TT_SWEEP_EARLY_ABORT_EN
            fidx_nx = vec_q;
`endif
          end
          // vec holds on the final sample so it never wraps back to 0
          if (stop) begin
            state_nx = DONE;
            pass_nx  = (mm_nx == '0);
          end else begin
            vec_nx = vec_q + N_IN'(1);
          end
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      mm_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef TT_SWEEP_EARLY_ABORT_EN
      fidx_q  <= '0;
`endif
    end else begin
      state_q <= state_nx;
      vec_q   <= vec_nx;
      tt_q    <= tt_nx;
      exp_q   <= exp_nx;
      mm_q    <= mm_nx;
      busy_q  <= busy_nx;
      done_q  <= (state_nx == DONE);
      pass_q  <= pass_nx;
`ifdef TT_SWEEP_EARLY_ABORT_EN
      fidx_q  <= fidx_nx;
`endif
    end
  end

  assign bus.vec          = vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.tt           = tt_q;
  assign bus.mismatch_cnt = mm_q;
  assign bus.pass         = pass_q;
`ifdef TT_SWEEP_EARLY_ABORT_EN
  assign bus.fail_idx     = fidx_q;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: a settle-0 and a settle-2 instance, table-driven sweeps
// plus hand sequences for start re-pulse, mid-sweep reset and reset/start collision.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_sweep_ctrl_if #(.N_IN(4)) bus0 ();
  tt_sweep_ctrl_if #(.N_IN(4)) bus2 ();

  tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // fmode 0: a&b, 1: constant 0, 2: parity of all inputs
  int fmode = 0;
  int cur   = 0;
  assign bus0.f_in = (fmode == 0) ? (bus0.vec[3] & bus0.vec[2]) :
                     (fmode == 1) ? 1'b0 : ^bus0.vec;
  assign bus2.f_in = ^bus2.vec;

  logic        o_done, o_busy, o_pass;
  logic [3:0]  o_vec;
  logic [15:0] o_tt;
  logic [4:0]  o_mm;
  assign o_done = (cur == 1) ? bus2.done : bus0.done;
  assign o_busy = (cur == 1) ? bus2.busy : bus0.busy;
  assign o_pass = (cur == 1) ? bus2.pass : bus0.pass;
  assign o_vec  = (cur == 1) ? bus2.vec  : bus0.vec;
  assign o_tt   = (cur == 1) ? bus2.tt   : bus0.tt;
  assign o_mm   = (cur == 1) ? bus2.mismatch_cnt : bus0.mismatch_cnt;
`ifdef TT_SWEEP_EARLY_ABORT_EN
  logic [3:0] o_fidx;
  assign o_fidx = (cur == 1) ? bus2.fail_idx : bus0.fail_idx;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          sel;
    int          fm;
    logic [15:0] expv;
    int          edges;
    logic [15:0] ttv;
    int          mm;
    logic        passv;
    int          fidx;
  } vec_t;

  vec_t tbl[7];

  // Pulse start on the selected instance and count edges until done; also tracks vec.
  task automatic run_sweep(input int sel, input logic [15:0] expv, input int settle,
                           input int vcap, output int n, output bit vec_ok);
    int ev;
    cur = sel;
    if (sel == 1) begin bus2.expected = expv; bus2.start = 1'b1; end
    else          begin bus0.expected = expv; bus0.start = 1'b1; end
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bus2.start = 1'b0;
    n = 0;
    vec_ok = (o_vec == 4'd0);
    while (!o_done && n < 200) begin
      @(posedge clk); #1;
      n++;
      ev = n / (settle + 1);
      if (ev > vcap) ev = vcap;
      if (o_vec != 4'(ev)) vec_ok = 1'b0;
    end
  endtask

  initial begin
    int  n, first, dcount, guard;
    bit  vok;
    bus0.start = 1'b0; bus0.expected = '0;
    bus2.start = 1'b0; bus2.expected = '0;

`ifdef TT_SWEEP_EARLY_ABORT_EN
    tbl[0] = '{0, 0, 16'hF000, 16, 16'hF000,  0, 1'b1, 0};
    tbl[1] = '{0, 0, 16'h0000, 13, 16'h1000,  1, 1'b0, 12};
    tbl[2] = '{1, 2, 16'h6996, 48, 16'h6996,  0, 1'b1, 0};
    tbl[3] = '{0, 1, 16'h0010,  5, 16'h0000,  1, 1'b0, 4};
    tbl[4] = '{0, 2, 16'h0000,  2, 16'h0002,  1, 1'b0, 1};
    tbl[5] = '{0, 1, 16'hFFFF,  1, 16'h0000,  1, 1'b0, 0};
    tbl[6] = '{0, 0, 16'hF000, 16, 16'hF000,  0, 1'b1, 0};
`else
    tbl[0] = '{0, 0, 16'hF000, 16, 16'hF000,  0, 1'b1, 0};
    tbl[1] = '{0, 0, 16'h0000, 16, 16'hF000,  4, 1'b0, 0};
    tbl[2] = '{1, 2, 16'h6996, 48, 16'h6996,  0, 1'b1, 0};
    tbl[3] = '{0, 1, 16'h0010, 16, 16'h0000,  1, 1'b0, 0};
    tbl[4] = '{0, 2, 16'h0000, 16, 16'h6996,  8, 1'b0, 0};
    tbl[5] = '{0, 1, 16'hFFFF, 16, 16'h0000, 16, 1'b0, 0};
    tbl[6] = '{0, 0, 16'hF000, 16, 16'hF000,  0, 1'b1, 0};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    cur = 0;
    check("rst_vec",  32'(o_vec),  0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_tt",   32'(o_tt),   0);
    check("rst_mm",   32'(o_mm),   0);
    check("rst_pass", 32'(o_pass), 0);
    check("rst_busy2", 32'(bus2.busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      int settle;
      settle = (tbl[i].sel == 1) ? 2 : 0;
      fmode  = tbl[i].fm;
      run_sweep(tbl[i].sel, tbl[i].expv, settle, tbl[i].edges / (settle + 1) - 1, n, vok);
      check($sformatf("v%0d_edges", i), 32'(n), 32'(tbl[i].edges));
      check($sformatf("v%0d_vecseq", i), 32'(vok), 1);
      check($sformatf("v%0d_busy_in_done", i), 32'(o_busy), 1);
      check($sformatf("v%0d_tt", i), 32'(o_tt), 32'(tbl[i].ttv));
      check($sformatf("v%0d_mm", i), 32'(o_mm), 32'(tbl[i].mm));
      check($sformatf("v%0d_pass", i), 32'(o_pass), 32'(tbl[i].passv));
`ifdef TT_SWEEP_EARLY_ABORT_EN
      check($sformatf("v%0d_fidx", i), 32'(o_fidx), 32'(tbl[i].fidx));
`endif
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(o_done), 0);
      check($sformatf("v%0d_busy_after", i), 32'(o_busy), 0);
      check($sformatf("v%0d_tt_hold", i), 32'(o_tt), 32'(tbl[i].ttv));
      check($sformatf("v%0d_pass_hold", i), 32'(o_pass), 32'(tbl[i].passv));
      @(posedge clk); #1;
    end

    // start re-pulsed mid-sweep with different expected: ignored, latched table kept
    cur = 0; fmode = 0;
    bus0.expected = 16'hF000; bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    first = -1; dcount = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin bus0.start = 1'b1; bus0.expected = 16'h0000; end
      if (k == 6) bus0.start = 1'b0;
      @(posedge clk); #1;
      if (o_done) begin
        dcount++;
        if (first < 0) first = k;
      end
    end
    check("repulse_done_count", 32'(dcount), 1);
    check("repulse_done_edge", 32'(first), 16);
    check("repulse_tt", 32'(o_tt), 32'h0000F000);
    check("repulse_mm", 32'(o_mm), 0);
    check("repulse_pass", 32'(o_pass), 1);

    // Reset while vec == 5
    fmode = 2;
    bus0.expected = 16'h0000; bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    guard = 0;
    while (o_vec != 4'd5 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("midrst_reach_vec5", 32'(guard), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_vec",  32'(o_vec),  0);
    check("midrst_busy", 32'(o_busy), 0);
    check("midrst_tt",   32'(o_tt),   0);
    check("midrst_mm",   32'(o_mm),   0);
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      if (o_done) dcount++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 32'(dcount), 0);

    // rst and start in the same cycle: rst wins, nothing starts
    bus0.expected = 16'hF000; bus0.start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0; rst = 1'b0;
    check("rst_start_busy", 32'(o_busy), 0);
    @(posedge clk); #1;
    check("rst_start_busy_later", 32'(o_busy), 0);

    // Fresh sweep after reset completes normally
    fmode = 0;
    run_sweep(0, 16'hF000, 0, 15, n, vok);
    check("post_rst_edges", 32'(n), 16);
    check("post_rst_vecseq", 32'(vok), 1);
    check("post_rst_tt", 32'(o_tt), 32'h0000F000);
    check("post_rst_mm", 32'(o_mm), 0);
    check("post_rst_pass", 32'(o_pass), 1);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
